// File: rtl/tff_edge_counter.sv
// Edge counter on the A0 output of the toggle flip-flop stage: counts qualified
// edges up to a compare value sampled at start, then parks in DONE.
module tff_edge_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A0,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] count,
    output logic             edge_pulse,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             ovf_q, ovf_d;
    logic             a0_q, primed_q, pulse_q, busy_q, done_q;
    logic             rise, fall, q_edge;

    // primed masks the first cycle after reset, when a0_q does not yet reflect A0
    always_comb begin
        rise = primed_q & A0 & ~a0_q;
        fall = primed_q & ~A0 & a0_q;
        unique case (mode)
            2'b00:   q_edge = rise;
            2'b01:   q_edge = fall;
            2'b10:   q_edge = rise | fall;
            default: q_edge = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        ovf_d   = ovf_q;
        if (start) begin
            state_d = COUNT;
            count_d = '0;
            ovf_d   = 1'b0;
            cmp_d   = cmp;
        end else if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else if ((state_q == COUNT) && q_edge) begin
            count_d = count_q + ONE;
            if (count_q == '1) begin
                ovf_d = 1'b1;
            end
            // cmp_q == 0 naturally terminates only after a full wrap
            if (count_d == cmp_q) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            cmp_q    <= '0;
            ovf_q    <= 1'b0;
            a0_q     <= 1'b0;
            primed_q <= 1'b0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            ovf_q    <= ovf_d;
            a0_q     <= A0;
            primed_q <= 1'b1;
            pulse_q  <= q_edge;
            busy_q   <= (state_d == COUNT);
            done_q   <= (state_d == DONE);
        end
    end

    assign count      = count_q;
    assign edge_pulse = pulse_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_tff_edge_counter.sv
// Directed bench for tff_edge_counter; A0 is driven directly as the tff1 output.
module tb_tff_edge_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A0 = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] cmp = 8'd0;
    logic [7:0] count;
    logic       edge_pulse, busy, done, ovf;

    int unsigned tests = 0;
    int unsigned failed = 0;

    tff_edge_counter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .A0         (A0),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .cmp        (cmp),
        .count      (count),
        .edge_pulse (edge_pulse),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [7:0] c);
        mode  = m;
        cmp   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rise_edge();
        A0 = 1'b0;
        tick();
        A0 = 1'b1;
        tick();
    endtask

    initial begin
        // reset state, with A0 already high before release
        A0 = 1'b1;
        tick(); tick();
        chk("rst_count", count, 0);
        chk("rst_pulse", edge_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);

        // 1: first cycle after release must not see an edge
        rst = 1'b0;
        tick();
        chk("t1_primed_pulse", edge_pulse, 0);
        pulse_start(2'b00, 8'd5);
        chk("t1_busy", busy, 1);
        chk("t1_count0", count, 0);
        tick(); tick(); tick();
        chk("t1_pulse_idle_a0", edge_pulse, 0);
        chk("t1_count_still0", count, 0);

        // 2: rising edges only, cmp=4; A0 starts high so rises land on even toggles
        pulse_start(2'b00, 8'd4);
        chk("t2_busy", busy, 1);
        for (int k = 1; k <= 10; k++) begin
            A0 = ~A0;
            tick();
            chk($sformatf("t2_count_k%0d", k), count, (k / 2 > 4) ? 4 : k / 2);
            chk($sformatf("t2_pulse_k%0d", k), edge_pulse, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("t2_done_k%0d", k), done, (k >= 8) ? 1 : 0);
            chk($sformatf("t2_busy_k%0d", k), busy, (k >= 8) ? 0 : 1);
        end

        // 3: both edges, cmp=6
        pulse_start(2'b10, 8'd6);
        chk("t3_count0", count, 0);
        chk("t3_done0", done, 0);
        for (int k = 1; k <= 6; k++) begin
            A0 = ~A0;
            tick();
            chk($sformatf("t3_count_k%0d", k), count, k);
        end
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        A0 = ~A0;
        tick();
        chk("t3_count_hold", count, 6);
        chk("t3_pulse_in_done", edge_pulse, 1);

        // 4: cmp=0 runs a full wrap
        pulse_start(2'b10, 8'd0);
        for (int k = 1; k <= 255; k++) begin
            A0 = ~A0;
            tick();
        end
        chk("t4_count255", count, 255);
        chk("t4_ovf_pre", ovf, 0);
        chk("t4_busy_pre", busy, 1);
        A0 = ~A0;
        tick();
        chk("t4_count_wrap", count, 0);
        chk("t4_ovf", ovf, 1);
        chk("t4_done", done, 1);
        pulse_start(2'b10, 8'd9);
        chk("t4_ovf_clr", ovf, 0);
        chk("t4_busy_restart", busy, 1);

        // mode 11 freezes counting and pulses
        mode = 2'b11;
        A0 = ~A0; tick();
        A0 = ~A0; tick();
        chk("m11_count", count, 0);
        chk("m11_pulse", edge_pulse, 0);

        // 5: stop coincident with a rising edge at count=3
        pulse_start(2'b00, 8'd10);
        rise_edge(); rise_edge(); rise_edge();
        chk("t5_count3", count, 3);
        A0 = 1'b0;
        tick();
        A0 = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_busy", busy, 0);
        chk("t5_stop_count", count, 3);
        tick();
        chk("t5_idle_done", done, 0);
        chk("t5_idle_count", count, 3);
        pulse_start(2'b00, 8'd2);
        chk("t5_restart_count", count, 0);
        chk("t5_restart_busy", busy, 1);
        rise_edge();
        chk("t5_count1", count, 1);
        // start coincident with a rising edge discards that edge
        A0 = 1'b0;
        tick();
        A0 = 1'b1;
        pulse_start(2'b00, 8'd2);
        chk("t5_start_edge_count", count, 0);
        chk("t5_start_edge_busy", busy, 1);

        // 6: asynchronous reset mid-count
        pulse_start(2'b00, 8'd20);
        for (int k = 0; k < 5; k++) rise_edge();
        chk("t6_count5", count, 5);
        chk("t6_pulse_pre", edge_pulse, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_pulse", edge_pulse, 0);
        chk("t6_async_busy", busy, 0);
        tick();
        A0 = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_primed_pulse", edge_pulse, 0);
        chk("t6_idle_busy", busy, 0);
        rise_edge();
        chk("t6_pulse_after", edge_pulse, 1);
        chk("t6_idle_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
